// File: rtl/fb_scroll_ctrl.sv
// fb_scroll_ctrl: frame buffer owner; clears it, serves raster reads and copies waterfall lines in blanking.
// Define FB_FREEZE_EN to add a freeze input that suspends scroll stepping.
module fb_scroll_ctrl #(
  parameter int H_VISIBLE  = 320,
  parameter int V_VISIBLE  = 240,
  parameter int LINE_LEN   = 320,
  parameter int SCROLL_DIV = 4,
  parameter int ADDR_W     = 17,
  parameter int BIN_AW     = 9
) (
  input  logic              pixclk,
  input  logic              resetn,
  input  logic [8:0]        x,
  input  logic [7:0]        y,
  input  logic              lower_blank,
  input  logic              line_req,
`ifdef FB_FREEZE_EN
  input  logic              freeze,
`endif
  output logic              line_ack,
  output logic [BIN_AW-1:0] bin_raddr,
  output logic              bin_ren,
  input  logic [7:0]        bin_rdata,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              fb_we,
  output logic [7:0]        y_offset,
  output logic              clear_done,
  output logic              overrun
);
  typedef enum logic [1:0] {CLEAR, VIDEO, WRITE_LINE, WAIT_END} state_t;
  localparam int SD_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [SD_W-1:0]   SD_LAST  = SD_W'(SCROLL_DIV - 1);
  localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(H_VISIBLE * V_VISIBLE);
  localparam logic [ADDR_W-1:0] LL       = ADDR_W'(LINE_LEN);
  localparam logic [8:0]        V_ROWS   = 9'(V_VISIBLE);
  localparam logic [7:0]        V_LAST   = 8'(V_VISIBLE - 1);
  state_t state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_nx, vid_addr, wr_addr;
  logic [SD_W-1:0] scroll_div;
  logic [8:0] sum, row;
  logic pend, lb_q, lb_rise, frz, due, go_write, clear_end, wl_end;
  // Shift-add keeps the common 320-wide stride free of a multiplier.
  function automatic logic [ADDR_W-1:0] row_base(input logic [ADDR_W-1:0] r);
    return (H_VISIBLE == 320) ? (r << 8) + (r << 6) : r * ADDR_W'(H_VISIBLE);
  endfunction
`ifdef FB_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif
  assign cnt_nx    = cnt + 1'b1;
  assign lb_rise   = lower_blank & ~lb_q;
  assign due       = scroll_div == SD_LAST;
  assign go_write  = lb_rise & ~frz & due & (pend | line_req);
  assign clear_end = cnt == FB_WORDS;
  assign wl_end    = cnt == LL;
  assign sum       = {1'b0, y} + {1'b0, y_offset};
  assign row       = (sum >= V_ROWS) ? sum - V_ROWS : sum;
  assign vid_addr  = ADDR_W'(x) + row_base(ADDR_W'(row));
  assign wr_addr   = row_base(ADDR_W'(y_offset)) + cnt;
  // Bin data arrives one cycle after the read, exactly when its write is issued.
  assign fb_wdata  = (state == WRITE_LINE && fb_we) ? bin_rdata : 8'd0;
  always_comb begin
    state_d = state;
    case (state)
      CLEAR:      state_d = clear_end ? VIDEO : CLEAR;
      VIDEO:      state_d = (lb_rise & ~frz) ? (go_write ? WRITE_LINE : WAIT_END) : VIDEO;
      WRITE_LINE: state_d = wl_end ? WAIT_END : WRITE_LINE;
      WAIT_END:   state_d = lower_blank ? WAIT_END : VIDEO;
    endcase
  end
  always_ff @(posedge pixclk or negedge resetn)
    if (!resetn) state <= CLEAR;
    else state <= state_d;
  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      fb_addr    <= '0;
      fb_we      <= 1'b0;
      bin_raddr  <= '0;
      bin_ren    <= 1'b0;
      line_ack   <= 1'b0;
      y_offset   <= 8'd0;
      clear_done <= 1'b0;
      overrun    <= 1'b0;
      scroll_div <= '0;
      pend       <= 1'b0;
      lb_q       <= 1'b0;
      cnt        <= '0;
    end else begin
      lb_q     <= lower_blank;
      line_ack <= 1'b0;
      pend     <= line_req | (pend & ~(state == WRITE_LINE && wl_end));
      case (state)
        CLEAR: begin
          fb_we      <= ~clear_end;
          fb_addr    <= cnt;
          cnt        <= cnt_nx;
          clear_done <= clear_end;
        end
        VIDEO: begin
          fb_we   <= 1'b0;
          fb_addr <= vid_addr;
          if (lb_rise && !frz) scroll_div <= due ? '0 : scroll_div + 1'b1;
          if (go_write) begin
            cnt       <= '0;
            bin_ren   <= 1'b1;
            bin_raddr <= '0;
          end
        end
        WRITE_LINE: begin
          overrun   <= overrun | ~lower_blank;
          cnt       <= cnt_nx;
          bin_ren   <= cnt_nx < LL;
          bin_raddr <= BIN_AW'(cnt_nx);
          fb_we     <= ~wl_end;
          fb_addr   <= wr_addr;
          if (wl_end) begin
            line_ack <= 1'b1;
            y_offset <= (y_offset == V_LAST) ? 8'd0 : y_offset + 8'd1;
          end
        end
        WAIT_END: fb_we <= 1'b0;
      endcase
    end
  end
endmodule

// File: doc/fb_scroll_ctrl.md
Name: fb_scroll_ctrl

Overview:
- Owns the single-port 8b frame buffer RAM (H_VISIBLE x V_VISIBLE, 17b address).
- Shares it between two users: the video raster read stream during active lines, and the spectrum line writer during lower blanking.
- Maintains the circular scroll offset that produces the waterfall effect.
- Sits between the video timing block, the frequency-bin BRAM read port and the frame buffer RAM.

Parameters:
- H_VISIBLE, 320: pixels per line; row stride in frame buffer words.
- V_VISIBLE, 240: lines per frame; scroll wrap modulus.
- LINE_LEN, 320: bins copied per scroll line; must be <= H_VISIBLE.
- SCROLL_DIV, 4: blanking periods per scroll step; >= 1.
- ADDR_W, 17: frame buffer address width.
- BIN_AW, 9: bin BRAM address width.

Ports:
- pixclk  in  1  pixel clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- x  in  9  current raster column from video.
- y  in  8  current raster row from video.
- lower_blank  in  1  high during vertical lower blanking.
- line_req  in  1  single-cycle pulse: a new spectrum line is complete in the bin BRAM.
- line_ack  out  1  single-cycle pulse: the line has been copied into the frame buffer.
- bin_raddr  out  BIN_AW  bin BRAM read address.
- bin_ren  out  1  bin BRAM read enable; data returns 1 cycle later.
- bin_rdata  in  8  bin BRAM read data.
- fb_addr  out  ADDR_W  frame buffer address.
- fb_wdata  out  8  frame buffer write data.
- fb_we  out  1  frame buffer write enable.
- y_offset  out  8  current top-of-screen row in the frame buffer.
- clear_done  out  1  high once the initial clear has completed.
- overrun  out  1  sticky flag: blanking ended before a line copy finished.

Behaviour:
- Reset (async, resetn=0) values:
  - fb_addr=0, fb_wdata=0, fb_we=0, bin_raddr=0, bin_ren=0
  - line_ack=0, y_offset=0, clear_done=0, overrun=0
  - internal scroll_div=0, pend=0, state=CLEAR
- Reset asserted mid-operation aborts everything; the clear restarts after release.
- CLEAR:
  - fb_we=1, fb_wdata=0; fb_addr steps 0 .. H_VISIBLE*V_VISIBLE-1, one per cycle.
  - The cycle after the last address: fb_we=0, clear_done=1, go to VIDEO.
  - line_req pulses during CLEAR set pend.
- VIDEO:
  - fb_we=0. Registered fb_addr = x + row*H_VISIBLE, where row = (y+y_offset) mod V_VISIBLE, computed as y+y_offset-V_VISIBLE when y+y_offset >= V_VISIBLE.
  - Latency from x/y to fb_addr is 1 cycle. When H_VISIBLE=320, the multiply is done as (row<<8)+(row<<6).
  - On the rising edge of lower_blank: if scroll_div==SCROLL_DIV-1, set scroll_div=0, else increment it.
  - Go to WRITE_LINE only when scroll_div was SCROLL_DIV-1 and pend=1 (or line_req is high that same cycle). Otherwise go to WAIT_END.
- WRITE_LINE:
  - Cycle k (0..LINE_LEN-1): bin_ren=1, bin_raddr=k.
  - Cycle k+1: fb_we=1, fb_addr = (k) + y_offset*H_VISIBLE, fb_wdata=bin_rdata.
  - Duration is LINE_LEN+1 cycles.
  - The cycle after the last write: fb_we=0, bin_ren=0, line_ack=1 for 1 cycle, pend cleared.
  - y_offset = (y_offset==V_VISIBLE-1) ? 0 : y_offset+1. Go to WAIT_END.
  - If lower_blank falls before completion, the copy still completes and overrun is set (sticky until reset).
- WAIT_END: fb_we=0; when lower_blank==0, go to VIDEO.
- line_req handling:
  - line_req at any time sets pend.
  - line_req arriving in the same cycle as the line_ack clear keeps pend=1; set wins.
  - Multiple requests before a copy collapse to one.
- y_offset changes only at the end of WRITE_LINE, so it is stable for an entire visible frame.

Optional Feature:
- Macro FB_FREEZE_EN.
- Defined: adds input port freeze (1b). While freeze=1 at the lower_blank rising edge, no scroll decision is taken: scroll_div holds, WRITE_LINE is skipped, pend is retained, y_offset holds. Video reads continue normally.
- Undefined: no freeze port; behaviour as above.

Test Plan:
- Reset release, H=320, V=240 -> fb_we high for exactly 76800 cycles with addresses 0..76799, data 0; then clear_done=1.
- VIDEO with y_offset=10, y=235, x=5 -> fb_addr=5+5*320=1605 one cycle later, fb_we=0.
- line_req pulse, then 4 lower_blank periods (SCROLL_DIV=4) -> copy occurs only in the 4th blank. Bin data b=k^8'h5A appears at fb_addr 0..319 with y_offset=0; line_ack pulses once; y_offset becomes 1.
- Force y_offset=239, then one copy -> writes to rows at base 76480, then y_offset wraps to 0.
- lower_blank shortened to 100 cycles during a copy -> all 320 writes complete, overrun=1 and stays set; next frame VIDEO addresses are correct.
- Two line_req pulses before a due blank -> exactly one copy and one line_ack; pend=0 afterwards. With FB_FREEZE_EN and freeze=1 -> no copy, y_offset unchanged, pend still 1.
